// File: rtl/arm_enc_pkg.sv
// Shared types and constants for the ARM-style instruction encoder:
// request kinds, ALU opcodes, DP command field values and queue depth.
package arm_enc_pkg;

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    KIND_DP  = 2'd0,
    KIND_MEM = 2'd1,
    KIND_BR  = 2'd2,
    KIND_ILL = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_MOV = 3'd4
  } aluop_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  function automatic logic [3:0] dp_cmd(input logic [2:0] op);
    case (op)
      ALU_ADD: dp_cmd = CMD_ADD;
      ALU_SUB: dp_cmd = CMD_SUB;
      ALU_ORR: dp_cmd = CMD_ORR;
      ALU_MOV: dp_cmd = CMD_MOV;
      default: dp_cmd = CMD_AND;
    endcase
  endfunction

  function automatic logic aluop_legal(input logic [2:0] op);
    aluop_legal = (op <= ALU_MOV);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small circular FIFO holding encoded words; storage is not reset, only
// the pointers and occupancy count are.
module enc_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = do_push ? next_ptr(wr_q) : wr_q;
    rd_d  = do_pop  ? next_ptr(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes DP / MEM / BR requests into 32-bit ARM words, queues them, and
// tags each popped word with a running byte address.
module instr_encoder
  import arm_enc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [3:0]  in_cond,
  input  logic [2:0]  in_aluop,
  input  logic        in_s,
  input  logic        in_imm,
  input  logic        in_load,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [11:0] in_src2,
  input  logic [23:0] in_imm24,
  input  logic        base_we,
  input  logic [31:0] base_addr,
  input  logic        err_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] words_out
);

  logic [31:0] enc_word;
  logic        illegal, accept, push, pop;
  logic        fifo_empty, fifo_full;
  logic [31:0] addr_q, addr_d;
  logic [15:0] words_q, words_d;
  logic        err_q, err_d;

  always_comb begin
    enc_word = '0;
    illegal  = 1'b0;
    case (kind_e'(in_kind))
      KIND_DP: begin
        illegal  = ~aluop_legal(in_aluop);
        enc_word = {in_cond, 2'b00, in_imm, dp_cmd(in_aluop), in_s,
                    (in_aluop == ALU_MOV) ? 4'h0 : in_rn, in_rd, in_src2};
      end
      KIND_MEM: enc_word = {in_cond, 2'b01, ~in_imm, 1'b1, 1'b1, 1'b0, 1'b0,
                            in_load, in_rn, in_rd, in_src2};
      KIND_BR:  enc_word = {in_cond, 3'b101, 1'b0, in_imm24};
      default:  illegal  = 1'b1;
    endcase
  end

  // Ready depends only on occupancy: a pop in the same cycle never frees a slot early.
  assign in_ready  = reset & ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~illegal;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  enc_fifo #(
    .DATA_W(32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (enc_word),
    .dout_o (out_instr),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  always_comb begin
    addr_d  = addr_q;
    words_d = words_q;
    err_d   = err_q;
    if (pop) begin
      addr_d  = addr_q + 32'd4;
      words_d = words_q + 16'd1;
    end
    if (base_we) addr_d = base_addr;
    if (err_clr) err_d = 1'b0;
    if (accept && illegal) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  assign out_addr  = addr_q;
  assign words_out = words_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, FIFO fill,
// address counter wrap/override, sticky error and mid-run reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  in_kind;
  logic [3:0]  in_cond;
  logic [2:0]  in_aluop;
  logic        in_s, in_imm, in_load;
  logic [3:0]  in_rn, in_rd;
  logic [11:0] in_src2;
  logic [23:0] in_imm24;
  logic        base_we;
  logic [31:0] base_addr;
  logic        err_clr;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        err;
  logic [15:0] words_out;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_addr;
  logic [15:0] exp_words;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_cond(in_cond), .in_aluop(in_aluop), .in_s(in_s),
    .in_imm(in_imm), .in_load(in_load), .in_rn(in_rn), .in_rd(in_rd),
    .in_src2(in_src2), .in_imm24(in_imm24), .base_we(base_we),
    .base_addr(base_addr), .err_clr(err_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .words_out(words_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_dp(input logic [2:0] op, input logic s, input logic imm,
                        input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2);
    in_kind = 2'd0; in_cond = 4'hE; in_aluop = op; in_s = s; in_imm = imm;
    in_rn = rn; in_rd = rd; in_src2 = src2;
  endtask

  task automatic set_mem(input logic load, input logic [3:0] rn, input logic [3:0] rd,
                         input logic [11:0] src2);
    in_kind = 2'd1; in_cond = 4'hE; in_imm = 1'b1; in_load = load;
    in_rn = rn; in_rd = rd; in_src2 = src2;
  endtask

  task automatic set_br(input logic [23:0] off);
    in_kind = 2'd2; in_cond = 4'hE; in_imm24 = off;
  endtask

  task automatic accept_one();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic show_and_pop(input string tag, input logic [31:0] exp_instr);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, exp_instr);
    check({tag, "_addr"}, out_addr, exp_addr);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_addr  = exp_addr + 32'd4;
    exp_words = exp_words + 16'd1;
    check({tag, "_words"}, {16'd0, words_out}, {16'd0, exp_words});
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_kind = '0; in_cond = 4'hE; in_aluop = '0;
    in_s = 1'b0; in_imm = 1'b0; in_load = 1'b0; in_rn = '0; in_rd = '0;
    in_src2 = '0; in_imm24 = '0; base_we = 1'b0; base_addr = '0;
    err_clr = 1'b0; out_ready = 1'b0;
    exp_addr = 32'd0; exp_words = 16'd0;

    repeat (3) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_words", {16'd0, words_out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    set_dp(3'd0, 1'b0, 1'b1, 4'd2, 4'd1, 12'h005); accept_one();
    show_and_pop("add", 32'hE2821005);
    set_dp(3'd1, 1'b1, 1'b0, 4'd4, 4'd4, 12'h005); accept_one();
    show_and_pop("subs", 32'hE0544005);
    set_dp(3'd4, 1'b0, 1'b1, 4'd7, 4'd0, 12'h000); accept_one();
    show_and_pop("mov", 32'hE3A00000);
    set_mem(1'b1, 4'd0, 4'd3, 12'h008); accept_one();
    show_and_pop("ldr", 32'hE5903008);
    set_mem(1'b0, 4'd0, 4'd3, 12'h008); accept_one();
    show_and_pop("str", 32'hE5803008);
    set_br(24'hFFFFFE); accept_one();
    show_and_pop("br", 32'hEAFFFFFE);
    check("addr_after6", out_addr, 32'h18);

    // Fill: rebase to 0, four pushes fill the queue, a fifth is held off.
    base_we = 1'b1; base_addr = 32'h0;
    step();
    base_we = 1'b0;
    check("rebase_addr", out_addr, 32'h0);
    check("rebase_words", {16'd0, words_out}, 32'd6);
    for (int i = 1; i <= 4; i++) begin
      set_br(24'(i));
      accept_one();
    end
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    set_br(24'd5);
    in_valid = 1'b1;
    step();
    check("full_held_ready", {31'd0, in_ready}, 32'd0);
    check("fill_w0", out_instr, 32'hEA000001);
    check("fill_a0", out_addr, 32'h0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("nobypass_ready", {31'd0, in_ready}, 32'd1);
    check("fill_w1", out_instr, 32'hEA000002);
    check("fill_a1", out_addr, 32'h4);
    step();
    check("fill_w2", out_instr, 32'hEA000003);
    check("fill_a2", out_addr, 32'h8);
    step();
    check("fill_w3", out_instr, 32'hEA000004);
    check("fill_a3", out_addr, 32'hC);
    step();
    out_ready = 1'b0;
    check("fill_drained", {31'd0, out_valid}, 32'd0);
    check("fill_words", {16'd0, words_out}, 32'd10);
    check("fill_addr_end", out_addr, 32'h10);

    // Address wrap at 2^32.
    base_we = 1'b1; base_addr = 32'hFFFF_FFFC;
    step();
    base_we = 1'b0;
    check("wrap_base", out_addr, 32'hFFFF_FFFC);
    set_br(24'h11); accept_one();
    set_br(24'h12); accept_one();
    check("wrap_w0", out_instr, 32'hEA000011);
    out_ready = 1'b1;
    step();
    check("wrap_addr0", out_addr, 32'h0);
    check("wrap_w1", out_instr, 32'hEA000012);
    step();
    out_ready = 1'b0;
    check("wrap_addr4", out_addr, 32'h4);
    check("wrap_words", {16'd0, words_out}, 32'd12);

    // base_we coincident with a pop: popped word shown at old address, base wins.
    set_br(24'h21); accept_one();
    base_we = 1'b1; base_addr = 32'h100; out_ready = 1'b1;
    check("coinc_old_addr", out_addr, 32'h4);
    check("coinc_instr", out_instr, 32'hEA000021);
    step();
    base_we = 1'b0; out_ready = 1'b0;
    check("coinc_new_addr", out_addr, 32'h100);
    check("coinc_words", {16'd0, words_out}, 32'd13);
    check("coinc_empty", {31'd0, out_valid}, 32'd0);

    // Illegal requests and sticky error.
    in_kind = 2'd3;
    check("ill_ready", {31'd0, in_ready}, 32'd1);
    accept_one();
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_no_word", {31'd0, out_valid}, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("errclr", {31'd0, err}, 32'd0);
    set_dp(3'd5, 1'b0, 1'b0, 4'd1, 4'd1, 12'h001);
    err_clr = 1'b1;
    accept_one();
    err_clr = 1'b0;
    check("ill_dp_clr_err", {31'd0, err}, 32'd1);
    check("ill_dp_no_word", {31'd0, out_valid}, 32'd0);
    check("ill_words", {16'd0, words_out}, 32'd13);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("errclr2", {31'd0, err}, 32'd0);

    // Mid-run reset with three words queued.
    for (int i = 0; i < 3; i++) begin
      set_br(24'h30 + 24'(i));
      accept_one();
    end
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_addr", out_addr, 32'h100);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_addr", out_addr, 32'h0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_words", {16'd0, words_out}, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    exp_addr = 32'd0; exp_words = 16'd0;
    set_dp(3'd0, 1'b0, 1'b1, 4'd2, 4'd1, 12'h005); accept_one();
    show_and_pop("post_rst_add", 32'hE2821005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning), clock and reset first:
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-low reset (asserted when 0).
  in_valid  in  1  encode request valid.
  in_ready  out  1  request accepted when in_valid and in_ready are both 1 on a rising edge.
  in_kind  in  2  0=DP, 1=MEM, 2=BR, 3=illegal.
  in_cond  in  4  condition field.
  in_aluop  in  3  0=ADD, 1=SUB, 2=AND, 3=ORR, 4=MOV, 5..7 illegal.
  in_s  in  1  DP S-bit.
  in_imm  in  1  DP: immediate Src2; MEM: immediate offset.
  in_load  in  1  MEM: 1=LDR, 0=STR.
  in_rn, in_rd  in  4 each  register fields.
  in_src2  in  12  DP Src2 or MEM imm12.
  in_imm24  in  24  branch offset.
  base_we  in  1  load address counter.
  base_addr  in  32  new byte address.
  err_clr  in  1  clear the sticky error flag.
  out_valid  out  1  encoded word available.
  out_ready  in  1  consumer takes the word on valid and ready.
  out_instr  out  32  encoded instruction.
  out_addr  out  32  byte address for out_instr.
  err  out  1  sticky illegal-request flag.
  words_out  out  16  count of words popped.

Function
REQ-002 DP encoding SHALL be {cond, 2'b00, in_imm, cmd, in_s, in_rn, in_rd, in_src2}; cmd SHALL be ADD=0100, SUB=0010, AND=0000, ORR=1100, MOV=1101; the Rn field SHALL be forced to 0 for MOV.
REQ-003 MEM encoding SHALL be {cond, 2'b01, ~in_imm, P=1, U=1, B=0, W=0, in_load, in_rn, in_rd, in_src2}.
REQ-004 BR encoding SHALL be {cond, 3'b101, L=0, in_imm24}.
REQ-005 Encoding SHALL be combinational from the request fields and SHALL be written into a 4-entry FIFO on acceptance.
REQ-006 in_ready SHALL be 1 exactly when the FIFO holds fewer than 4 entries; there SHALL be no full-FIFO bypass, even when a pop occurs in the same cycle.
REQ-007 A word accepted at edge N SHALL appear on out_instr with out_valid=1 after edge N when the FIFO was empty, giving a latency of 1 cycle.
REQ-008 out_valid SHALL equal FIFO non-empty; out_instr and out_valid SHALL stay stable until popped.
REQ-009 The FIFO SHALL preserve order, and a simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-010 out_addr SHALL show the address counter; each pop SHALL increment the counter by 4, wrapping modulo 2^32.
REQ-011 When base_we is 1, the counter SHALL load base_addr; when a pop happens in the same cycle, the popped word SHALL keep the old address and base_addr SHALL win the update.
REQ-012 words_out SHALL increment on each pop and wrap at 2^16; base_we SHALL NOT affect it.
REQ-013 An illegal request (in_kind=3, or DP with in_aluop>4) SHALL be accepted (handshake completes) but not pushed, and err SHALL be set.
REQ-014 err SHALL stay set until err_clr; when err_clr and an illegal acceptance occur in the same cycle, err SHALL be 1.

Reset
REQ-015 While reset=0: FIFO empty, out_valid=0, in_ready=0, out_addr=0, words_out=0, err=0.
REQ-016 Reset asserted mid-operation SHALL discard all FIFO contents immediately; in_ready SHALL rise in the first cycle after release.

Structure
REQ-017 Package arm_enc_pkg SHALL hold the kind and aluop enums, the DP cmd constants, and the FIFO depth constant (4).
REQ-018 The FIFO SHALL be a sub-module enc_fifo (32-bit data, parameterised depth); encoding, the address counter, and error logic SHALL live in instr_encoder.

Verification
REQ-019 DP ADD, cond=E, imm=1, rn=2, rd=1, src2=005 -> out_instr=E2821005 at out_addr=0, one cycle after acceptance.
REQ-020 SUBS reg (s=1, imm=0, rn=4, rd=4, src2=005) -> E0544005; MOV imm rn=7, rd=0, src2=0 -> E3A00000 (Rn forced 0).
REQ-021 LDR rn=0, rd=3, src2=008 -> E5903008; STR with the same fields -> E5803008; BR imm24=FFFFFE -> EAFFFFFE.
REQ-022 out_ready=0, push 5 requests -> in_ready drops after 4; release out_ready -> 4 words popped in order at addresses 0, 4, 8, C; words_out=4.
REQ-023 base_we with base_addr=FFFFFFFC, then 2 pops -> out_addr FFFFFFFC then 00000000; base_we coincident with a pop -> popped word keeps old address.
REQ-024 in_kind=3 accepted -> no output word and err=1; err_clr -> err=0; reset pulse with 3 words queued -> out_valid=0 and out_addr=0.
